// File: rtl/gate_equiv_sequencer_pkg.sv
// Shared types for the gate equivalence sequencer: FSM state encoding and settle counter width.
package gates_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam int SETTLE_W = 4;

endpackage

// File: rtl/gate_equiv_sequencer_timer.sv
// gate_settle_timer: loadable down-counter with zero flag; load wins over decrement.
module gate_settle_timer
   import gates_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_load,
   input  logic [SETTLE_W-1:0] i_load_val,
   input  logic                i_dec,
   output logic [SETTLE_W-1:0] o_cnt,
   output logic                o_zero
);

   logic [SETTLE_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - SETTLE_W'(1);
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_equiv_sequencer.sv
// Exhaustive truth-table sweep comparing two gate implementations.
// Optional build macro GATE_EQUIV_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module gate_equiv_sequencer
   import gates_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            dut_a,
   input  logic            dut_b,
   output logic [N_IN-1:0] vec,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic [N_IN-1:0] first_bad
);

   localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);
   localparam state_t AFTER_VEC = (SETTLE == 0) ? S_CHECK : S_SETTLE;

   state_t              r_state;
   state_t              w_next;
   logic [N_IN-1:0]     r_vec;
   logic [N_IN:0]       r_err_cnt;
   logic [N_IN-1:0]     r_first_bad;
   logic                r_pass;
   logic [N_IN:0]       w_err_nxt;
   logic [SETTLE_W-1:0] w_cnt;
   logic                w_zero;
   logic                w_mis;
   logic                w_stop;
   logic                w_clear;
   logic                w_load;
   logic                w_dec;
   logic                w_inc;
   logic                w_fin;

   gate_settle_timer u_timer (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_load     (w_load),
      .i_load_val (SETTLE_LD),
      .i_dec      (w_dec),
      .o_cnt      (w_cnt),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_clear = 1'b0;
      w_load  = 1'b0;
      w_dec   = 1'b0;
      w_inc   = 1'b0;
      w_fin   = 1'b0;
      w_mis   = dut_a ^ dut_b;
`ifdef GATE_EQUIV_STOP_ON_FAIL_EN
      w_stop  = w_mis;
`else
      w_stop  = 1'b0;
`endif
      w_err_nxt = r_err_cnt + (N_IN+1)'(w_mis);
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_clear = 1'b1;
               w_load  = 1'b1;
               w_next  = AFTER_VEC;
            end
         end
         S_SETTLE: begin
            w_dec = 1'b1;
            // zero guards against a lost load ever trapping the FSM in SETTLE
            if ((w_cnt == SETTLE_W'(1)) || w_zero) begin
               w_next = S_CHECK;
            end
         end
         S_CHECK: begin
            if ((&r_vec) || w_stop) begin
               w_fin  = 1'b1;
               w_next = S_DONE;
            end else begin
               w_inc  = 1'b1;
               w_load = 1'b1;
               w_next = AFTER_VEC;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vec       <= '0;
         r_err_cnt   <= '0;
         r_first_bad <= '0;
         r_pass      <= 1'b0;
      end else if (w_clear) begin
         r_vec       <= '0;
         r_err_cnt   <= '0;
         r_first_bad <= '0;
         r_pass      <= 1'b0;
      end else if (r_state == S_CHECK) begin
         if (w_mis) begin
            r_err_cnt <= w_err_nxt;
            if (r_err_cnt == '0) begin
               r_first_bad <= r_vec;
            end
         end
         if (w_inc) begin
            r_vec <= r_vec + N_IN'(1);
         end
         if (w_fin) begin
            r_pass <= (w_err_nxt == '0);
         end
      end
   end

   assign vec       = r_vec;
   assign err_cnt   = r_err_cnt;
   assign first_bad = r_first_bad;
   assign pass      = r_pass;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_gate_equiv_sequencer.sv
// Bench for gate_equiv_sequencer: two configurations, truth tables modelled as bit masks.
module tb_gate_equiv_sequencer;

   logic clk;
   logic rst0, rst1, start0, start1;
   logic [3:0] mask0;
   logic [7:0] mask1;

   logic [1:0] vec0, fb0;
   logic [2:0] err0;
   logic       busy0, done0, pass0, a0, b0;
   logic [2:0] vec1, fb1;
   logic [3:0] err1;
   logic       busy1, done1, pass1, a1, b1;

   int sel;
   int unsigned s_vec, s_err, s_fb, s_busy, s_done, s_pass;
   int unsigned n_checks, n_errors;

   assign a0 = |vec0;
   assign b0 = mask0[vec0];
   assign a1 = |vec1;
   assign b1 = mask1[vec1];

   gate_equiv_sequencer #(.N_IN(2), .SETTLE(1)) u_dut2 (
      .clk(clk), .rst(rst0), .start(start0), .dut_a(a0), .dut_b(b0),
      .vec(vec0), .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err0), .first_bad(fb0)
   );

   gate_equiv_sequencer #(.N_IN(3), .SETTLE(0)) u_dut3 (
      .clk(clk), .rst(rst1), .start(start1), .dut_a(a1), .dut_b(b1),
      .vec(vec1), .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .first_bad(fb1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      if (sel != 0) begin
         s_vec = 32'(vec1);  s_err  = 32'(err1);  s_fb   = 32'(fb1);
         s_busy = 32'(busy1); s_done = 32'(done1); s_pass = 32'(pass1);
      end else begin
         s_vec = 32'(vec0);  s_err  = 32'(err0);  s_fb   = 32'(fb0);
         s_busy = 32'(busy0); s_done = 32'(done0); s_pass = 32'(pass0);
      end
   end

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_start(input bit v);
      if (sel != 0) start1 = v;
      else          start0 = v;
   endtask

   task automatic run_sweep(input int inst, input logic [7:0] mask, input bit pulses);
      int unsigned n, s, nv, exp_err, exp_fb, exp_vec, exp_done, cyc, a_v;
      bit found;
      sel = inst;
      n   = (inst != 0) ? 3 : 2;
      s   = (inst != 0) ? 0 : 1;
      nv  = 1 << n;
      if (inst != 0) mask1 = mask;
      else           mask0 = mask[3:0];
      exp_err = 0; exp_fb = 0; found = 0;
      for (int unsigned v = 0; v < nv; v++) begin
         a_v = (v != 0) ? 1 : 0;
         if (a_v != 32'(mask[v])) begin
            if (!found) exp_fb = v;
            found = 1;
            exp_err++;
         end
      end
      exp_vec  = nv - 1;
      exp_done = 1 + nv * (s + 1);
`ifdef GATE_EQUIV_STOP_ON_FAIL_EN
      if (found) begin
         exp_err  = 1;
         exp_vec  = exp_fb;
         exp_done = 1 + (exp_fb + 1) * (s + 1);
      end
`endif
      @(posedge clk); #1;
      set_start(1'b1);
      @(posedge clk); #1;
      set_start(1'b0);
      cyc = 1;
      while (s_done == 0 && cyc < 300) begin
         check("busy_during", s_busy, 1);
         check("vec_step", s_vec, (cyc - 1) / (s + 1));
         set_start(pulses && (cyc == 3 || $urandom_range(0, 3) == 0));
         @(posedge clk); #1;
         cyc++;
      end
      check("done_seen", s_done, 1);
      check("latency", cyc, exp_done);
      check("busy_at_done", s_busy, 1);
      check("vec_end", s_vec, exp_vec);
      check("err_end", s_err, exp_err);
      check("first_bad", s_fb, exp_fb);
      set_start(pulses);
      @(posedge clk); #1;
      set_start(1'b0);
      check("done_pulse", s_done, 0);
      check("busy_after", s_busy, 0);
      check("pass", s_pass, (exp_err == 0) ? 1 : 0);
      repeat (2) @(posedge clk);
      #1;
      check("idle_done", s_done, 0);
      check("idle_busy", s_busy, 0);
      check("hold_vec", s_vec, exp_vec);
      check("hold_err", s_err, exp_err);
      check("hold_fb", s_fb, exp_fb);
   endtask

   task automatic reset_mid();
      int unsigned guard, pulses;
      sel = 0;
      mask0 = 4'b1110;
      @(posedge clk); #1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      guard = 0;
      while (vec0 != 2'b10 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("reach_vec2", 32'(vec0), 2);
      rst0 = 1'b1;
      @(posedge clk); #1;
      rst0 = 1'b0;
      check("rst_vec", s_vec, 0);
      check("rst_busy", s_busy, 0);
      check("rst_err", s_err, 0);
      check("rst_done", s_done, 0);
      check("rst_fb", s_fb, 0);
      pulses = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done0) pulses++;
      end
      check("no_done_after_rst", pulses, 0);
   endtask

   initial begin
      logic [7:0] m;
      n_checks = 0; n_errors = 0;
      sel = 0;
      rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
      mask0 = 4'b1110; mask1 = 8'hFE;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         sel = i;
         #1;
         check("reset_vec", s_vec, 0);
         check("reset_busy", s_busy, 0);
         check("reset_done", s_done, 0);
         check("reset_pass", s_pass, 0);
         check("reset_err", s_err, 0);
         check("reset_fb", s_fb, 0);
      end
      rst0 = 1'b0; rst1 = 1'b0;

      run_sweep(0, 8'h0E, 1'b0);
      run_sweep(0, 8'h08, 1'b0);
      run_sweep(0, 8'h0E, 1'b1);
      reset_mid();
      run_sweep(0, 8'h0E, 1'b0);
      run_sweep(1, 8'hFE, 1'b0);
      run_sweep(1, 8'h80, 1'b1);

      for (int k = 0; k < 10; k++) begin
         int inst;
         inst = int'($urandom_range(0, 1));
         m = 8'($urandom);
         if ($urandom_range(0, 2) == 0) m = (inst != 0) ? 8'hFE : 8'h0E;
         run_sweep(inst, m, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
